vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. It is the source of the horizontal_num / load_enable stream consumed by the pattern and colour blocks. It also produces hsync/vsync/blank_n, which are delayed so they stay aligned with the colour block's one-cycle registered RGB. Sits between the clock/reset logic and all pixel generators; drives the DAC sync pins.

---
 rtl/vga_timing_if.sv | 25 ++
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing generator and the pixel/colour blocks.
// master drives counters, decodes and delayed syncs; slave supplies the advance enable.
interface vga_timing_if;
  logic       enable;
  logic [9:0] horizontal_num;
  logic [9:0] vertical_num;
  logic       load_enable;
  logic       line_start;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic       blank_n;

  modport master (
    input  enable,
    output horizontal_num, vertical_num, load_enable, line_start, frame_start,
    output hsync, vsync, blank_n
  );

  modport slave (
    output enable,
    input  horizontal_num, vertical_num, load_enable, line_start, frame_start,
    input  hsync, vsync, blank_n
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counters with registered decodes; syncs/blank_n lag by PIPE_DLY clocks.
// enable=0 holds counters and sync pipeline while clearing the visible/start strobes.
module vga_timing_gen #(
  parameter int HVID     = 640,
  parameter int HFP      = 16,
  parameter int HSP      = 96,
  parameter int HBP      = 48,
  parameter int VVID     = 480,
  parameter int VFP      = 10,
  parameter int VSP      = 2,
  parameter int VBP      = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_DLY = 1
) (
  input  logic         clk_25,
  input  logic         n_rst,
  vga_timing_if.master bus
);

  localparam int HTOT = HVID + HFP + HSP + HBP;
  localparam int VTOT = VVID + VFP + VSP + VBP;

  localparam logic [9:0] H_LAST     = 10'(HTOT - 1);
  localparam logic [9:0] V_LAST     = 10'(VTOT - 1);
  localparam logic [9:0] H_VIS      = 10'(HVID);
  localparam logic [9:0] V_VIS      = 10'(VVID);
  localparam logic [9:0] H_SYNC_ON  = 10'(HVID + HFP);
  localparam logic [9:0] H_SYNC_OFF = 10'(HVID + HFP + HSP);
  localparam logic [9:0] V_SYNC_ON  = 10'(VVID + VFP);
  localparam logic [9:0] V_SYNC_OFF = 10'(VVID + VFP + VSP);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = !SYNC_POL;

  if (HTOT > 1024 || VTOT > 1024) begin : g_bad_geometry
    $error("vga_timing_gen: HTOT and VTOT must not exceed 1024");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_pipe_dly
    $error("vga_timing_gen: PIPE_DLY must be within 0..4");
  end

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       vis_next;
  logic       hs_act_next;
  logic       vs_act_next;

  // vis_raw keeps the visibility decode through a pause so the blank pipeline
  // resumes with the right value, while load_enable itself is forced low.
  logic       vis_raw;
  logic       hs_raw;
  logic       vs_raw;
  logic       le_q;
  logic       ls_q;
  logic       fs_q;

  always_comb begin
    h_next = (h_cnt == H_LAST) ? 10'd0 : h_cnt + 10'd1;
    v_next = v_cnt;
    if (h_cnt == H_LAST) begin
      v_next = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
    vis_next    = (h_next < H_VIS) && (v_next < V_VIS);
    hs_act_next = (h_next >= H_SYNC_ON) && (h_next < H_SYNC_OFF);
    vs_act_next = (v_next >= V_SYNC_ON) && (v_next < V_SYNC_OFF);
  end

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      h_cnt   <= H_LAST;
      v_cnt   <= V_LAST;
      vis_raw <= 1'b0;
      hs_raw  <= SYNC_OFF;
      vs_raw  <= SYNC_OFF;
      le_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else if (bus.enable) begin
      h_cnt   <= h_next;
      v_cnt   <= v_next;
      vis_raw <= vis_next;
      hs_raw  <= hs_act_next ? SYNC_ON : SYNC_OFF;
      vs_raw  <= vs_act_next ? SYNC_ON : SYNC_OFF;
      le_q    <= vis_next;
      ls_q    <= (h_next == 10'd0);
      fs_q    <= (h_next == 10'd0) && (v_next == 10'd0);
    end else begin
      le_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end
  end

  if (PIPE_DLY == 0) begin : g_no_pipe
    assign bus.hsync   = hs_raw;
    assign bus.vsync   = vs_raw;
    assign bus.blank_n = vis_raw;
  end else begin : g_pipe
    logic [PIPE_DLY-1:0] hs_sr;
    logic [PIPE_DLY-1:0] vs_sr;
    logic [PIPE_DLY-1:0] bl_sr;

    always_ff @(posedge clk_25 or negedge n_rst) begin
      if (!n_rst) begin
        hs_sr <= {PIPE_DLY{SYNC_OFF}};
        vs_sr <= {PIPE_DLY{SYNC_OFF}};
        bl_sr <= '0;
      end else if (bus.enable) begin
        hs_sr[0] <= hs_raw;
        vs_sr[0] <= vs_raw;
        bl_sr[0] <= vis_raw;
        for (int i = 1; i < PIPE_DLY; i++) begin
          hs_sr[i] <= hs_sr[i-1];
          vs_sr[i] <= vs_sr[i-1];
          bl_sr[i] <= bl_sr[i-1];
        end
      end
    end

    assign bus.hsync   = hs_sr[PIPE_DLY-1];
    assign bus.vsync   = vs_sr[PIPE_DLY-1];
    assign bus.blank_n = bl_sr[PIPE_DLY-1];
  end

  assign bus.horizontal_num = h_cnt;
  assign bus.vertical_num   = v_cnt;
  assign bus.load_enable    = le_q;
  assign bus.line_start     = ls_q;
  assign bus.frame_start    = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default geometry at PIPE_DLY 0/1/3 against a cycle model, plus a
// small active-high-sync geometry for frame-level timing and mid-frame reset.
module tb_vga_timing_gen;
  logic clk_25 = 1'b0;
  logic n_rst  = 1'b0;
  logic en     = 1'b1;

  always #20 clk_25 = ~clk_25;

  vga_timing_if b0 ();
  vga_timing_if b1 ();
  vga_timing_if b3 ();
  vga_timing_if bs ();

  assign b0.enable = en;
  assign b1.enable = en;
  assign b3.enable = en;
  assign bs.enable = en;

  vga_timing_gen #(.PIPE_DLY(0)) u_d0 (.clk_25(clk_25), .n_rst(n_rst), .bus(b0));
  vga_timing_gen                 u_d1 (.clk_25(clk_25), .n_rst(n_rst), .bus(b1));
  vga_timing_gen #(.PIPE_DLY(3)) u_d3 (.clk_25(clk_25), .n_rst(n_rst), .bus(b3));
  vga_timing_gen #(
    .HVID(8), .HFP(2), .HSP(3), .HBP(1),
    .VVID(4), .VFP(1), .VSP(2), .VBP(1),
    .SYNC_POL(1'b1), .PIPE_DLY(1)
  ) u_sm (.clk_25(clk_25), .n_rst(n_rst), .bus(bs));

  int   errors = 0;
  int   checks = 0;
  int   mm     = 0;
  int   mh, mv;
  logic last_en;
  logic hl [0:3];
  logic hh [0:3];
  logic hv [0:3];

  int le_cnt, hs_low, hs_first0, hs_first1, ls_cnt, n, pb;
  int fs_gap, sm_le, sm_vs, vs_first_h, vs_first_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mh = 799;
    mv = 524;
    last_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hl[i] = 1'b0;
      hh[i] = 1'b0;
      hv[i] = 1'b0;
    end
  endtask

  task automatic model_adv();
    if (mh == 799) begin
      mh = 0;
      mv = (mv == 524) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    for (int i = 3; i > 0; i--) begin
      hl[i] = hl[i-1];
      hh[i] = hh[i-1];
      hv[i] = hv[i-1];
    end
    hl[0] = (mh < 640) && (mv < 480);
    hh[0] = (mh >= 656) && (mh < 752);
    hv[0] = (mv >= 490) && (mv < 492);
  endtask

  // Active-low syncs: asserted decode shows as 0 on the pin.
  task automatic cmp_build(input logic [9:0] h, input logic [9:0] v, input logic le,
                           input logic ls, input logic fs, input logic hs,
                           input logic vs, input logic bn, input int d);
    if (h !== 10'(mh) || v !== 10'(mv) || le !== (last_en && hl[0]) ||
        ls !== (last_en && mh == 0) || fs !== (last_en && mh == 0 && mv == 0) ||
        hs !== !hh[d] || vs !== !hv[d] || bn !== hl[d])
      mm++;
  endtask

  task automatic tick();
    @(negedge clk_25);
    if (!n_rst) model_reset();
    else if (en) begin
      model_adv();
      last_en = 1'b1;
    end else last_en = 1'b0;
    cmp_build(b0.horizontal_num, b0.vertical_num, b0.load_enable, b0.line_start,
              b0.frame_start, b0.hsync, b0.vsync, b0.blank_n, 0);
    cmp_build(b1.horizontal_num, b1.vertical_num, b1.load_enable, b1.line_start,
              b1.frame_start, b1.hsync, b1.vsync, b1.blank_n, 1);
    cmp_build(b3.horizontal_num, b3.vertical_num, b3.load_enable, b3.line_start,
              b3.frame_start, b3.hsync, b3.vsync, b3.blank_n, 3);
  endtask

  initial begin
    model_reset();
    n_rst = 1'b0;
    en    = 1'b1;
    repeat (5) tick();
    chk("rst_h", b1.horizontal_num, 799);
    chk("rst_v", b1.vertical_num, 524);
    chk("rst_le", b1.load_enable, 0);
    chk("rst_hsync", b1.hsync, 1);
    chk("rst_vsync", b1.vsync, 1);
    chk("rst_blank_n", b1.blank_n, 0);
    chk("rst_hsync_d3", b3.hsync, 1);
    chk("rst_sm_hsync", bs.hsync, 0);

    n_rst = 1'b1;
    tick();
    chk("first_h", b1.horizontal_num, 0);
    chk("first_v", b1.vertical_num, 0);
    chk("first_le", b1.load_enable, 1);
    chk("first_fs", b1.frame_start, 1);
    chk("first_ls", b1.line_start, 1);
    chk("first_bn_d1", b1.blank_n, 0);
    chk("first_bn_d0", b0.blank_n, 1);
    chk("first_sm_fs", bs.frame_start, 1);

    le_cnt = 0; hs_low = 0; hs_first0 = -1; hs_first1 = -1; ls_cnt = 0;
    for (int k = 0; k < 800; k++) begin
      if (b1.load_enable) le_cnt++;
      if (b1.line_start) ls_cnt++;
      if (!b1.hsync) begin
        hs_low++;
        if (hs_first1 < 0) hs_first1 = int'(b1.horizontal_num);
      end
      if (!b0.hsync && hs_first0 < 0) hs_first0 = int'(b0.horizontal_num);
      tick();
    end
    chk("line_le_cnt", le_cnt, 640);
    chk("line_hs_low", hs_low, 96);
    chk("line_hs_first_d1", hs_first1, 657);
    chk("line_hs_first_d0", hs_first0, 656);
    chk("line_ls_cnt", ls_cnt, 1);
    chk("line_next_ls", b1.line_start, 1);
    chk("line_next_h", b1.horizontal_num, 0);
    chk("line_next_v", b1.vertical_num, 1);

    n = 0;
    while (!(b1.horizontal_num == 10'd300 && b1.vertical_num == 10'd10) && n < 10000) begin
      tick();
      n++;
    end
    chk("reach_300_10", (b1.horizontal_num == 10'd300 && b1.vertical_num == 10'd10), 1);
    en = 1'b0;
    pb = 0;
    repeat (7) begin
      tick();
      if (b1.horizontal_num !== 10'd300 || b1.vertical_num !== 10'd10 ||
          b1.load_enable !== 1'b0 || b1.line_start !== 1'b0)
        pb++;
    end
    chk("pause_hold", pb, 0);
    chk("pause_blank_n", b1.blank_n, 1);
    en = 1'b1;
    tick();
    chk("resume_h", b1.horizontal_num, 301);
    chk("resume_v", b1.vertical_num, 10);
    chk("resume_le", b1.load_enable, 1);

    n = 0;
    while (bs.frame_start !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("sm_find_fs", bs.frame_start, 1);
    fs_gap = -1; sm_le = 0; sm_vs = 0; vs_first_h = -1; vs_first_v = -1;
    for (int k = 0; k < 224; k++) begin
      if (k > 0 && bs.frame_start && fs_gap < 0) fs_gap = k;
      if (k < 112) begin
        if (bs.load_enable) sm_le++;
        if (bs.vsync) begin
          sm_vs++;
          if (vs_first_h < 0) begin
            vs_first_h = int'(bs.horizontal_num);
            vs_first_v = int'(bs.vertical_num);
          end
        end
      end
      tick();
    end
    chk("sm_frame_period", fs_gap, 112);
    chk("sm_le_per_frame", sm_le, 32);
    chk("sm_vsync_clocks", sm_vs, 28);
    chk("sm_vsync_first_h", vs_first_h, 1);
    chk("sm_vsync_first_v", vs_first_v, 5);

    n = 0;
    while (!(bs.horizontal_num == 10'd11 && bs.vertical_num == 10'd5) && n < 300) begin
      tick();
      n++;
    end
    chk("sm_pre_hsync", bs.hsync, 1);
    chk("sm_pre_vsync", bs.vsync, 1);
    n_rst = 1'b0;
    #1;
    model_reset();
    chk("mid_h", b1.horizontal_num, 799);
    chk("mid_v", b1.vertical_num, 524);
    chk("mid_le", b1.load_enable, 0);
    chk("mid_hsync_d3", b3.hsync, 1);
    chk("mid_sm_h", bs.horizontal_num, 13);
    chk("mid_sm_v", bs.vertical_num, 7);
    chk("mid_sm_hsync", bs.hsync, 0);
    chk("mid_sm_vsync", bs.vsync, 0);
    repeat (2) tick();
    n_rst = 1'b1;
    tick();
    chk("post_fs", b1.frame_start, 1);
    chk("post_h", b1.horizontal_num, 0);
    chk("post_v", b1.vertical_num, 0);
    chk("post_sm_fs", bs.frame_start, 1);
    chk("post_sm_hsync", bs.hsync, 0);

    chk("model_track", mm, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
